regfile_dump_unit: RTL and testbench

REGFILE_DUMP_UNIT -- requirements
Module: regfile_dump_unit

---
 rtl/regfile_dump_unit_pkg.sv | 23 ++
 rtl/regfile_dump_unit.sv | 113 +++++++++++
 tb/tb_regfile_dump_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_unit_pkg.sv
// Shared constants and types for the register-file dump unit.
package regfile_dump_unit_pkg;

    localparam int RF_NUM_REGS   = 32;
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_IDX_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

    // Advance a register index, wrapping from the top register back to 0.
    function automatic logic [RF_IDX_W-1:0] next_idx(input logic [RF_IDX_W-1:0] idx,
                                                     input int num_regs);
        logic [RF_IDX_W-1:0] top;
        top = RF_IDX_W'(num_regs - 1);
        return (idx == top) ? '0 : idx + RF_IDX_W'(1);
    endfunction

endpackage

// File: rtl/regfile_dump_unit.sv
// Walks a range of architectural registers through a spare regfile read
// port and streams each value out over a valid/ready interface.
module regfile_dump_unit
    import regfile_dump_unit_pkg::*;
#(
    parameter int NUM_REGS   = RF_NUM_REGS,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [RF_IDX_W-1:0]   first_reg,
    input  logic [RF_IDX_W-1:0]   last_reg,
    output logic [RF_IDX_W-1:0]   ctrl_readReg,
    input  logic [DATA_WIDTH-1:0] data_readReg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RF_IDX_W-1:0]   out_reg,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    dump_state_e           state_q, state_d;
    logic [RF_IDX_W-1:0]   cur_q, cur_d;
    logic [RF_IDX_W-1:0]   last_q, last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [RF_IDX_W-1:0]   out_reg_q, out_reg_d;

    // State and datapath registers; reset aborts any dump in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            last_q     <= '0;
            out_data_q <= '0;
            out_reg_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            out_data_q <= out_data_d;
            out_reg_q  <= out_reg_d;
        end
    end

    // Next-state and datapath update: the range is latched only from IDLE,
    // so start/first/last are ignored for the rest of the dump.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        out_data_d = out_data_q;
        out_reg_d  = out_reg_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_d   = first_reg;
                    last_d  = last_reg;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // Read data is combinational from ctrl_readReg, so it is
                // captured in the same cycle the address is presented.
                out_data_d = data_readReg;
                out_reg_d  = cur_q;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (cur_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_d   = next_idx(cur_q, NUM_REGS);
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state; address is parked at 0
    // whenever no read is in flight.
    always_comb begin
        ctrl_readReg = '0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        unique case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_READ: ctrl_readReg = cur_q;
            ST_SEND: begin
                out_valid = 1'b1;
                out_last  = (out_reg_q == last_q);
            end
            ST_DONE: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign out_data = out_data_q;
    assign out_reg  = out_reg_q;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: a behavioural regfile feeds the read
// port, expected beats go into a queue, and a monitor checks every handshake.
module tb_regfile_dump_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  ctrl_readReg;
    logic [31:0] data_readReg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_reg;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    checks    = 0;
    int    errors    = 0;
    int    done_cnt  = 0;
    int    beat_cnt  = 0;

    always #5 clock = ~clock;

    assign data_readReg = regs[ctrl_readReg];

    regfile_dump_unit dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .first_reg    (first_reg),
        .last_reg     (last_reg),
        .ctrl_readReg (ctrl_readReg),
        .data_readReg (data_readReg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_reg      (out_reg),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    // Monitor: compare every accepted beat against the scoreboard head.
    always @(negedge clock) begin
        if (out_valid && out_ready && !reset) begin
            beat_t e;
            checks++;
            beat_cnt++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got reg=%0d data=%0d last=%0d, none expected",
                         out_reg, out_data, out_last);
            end else begin
                e = exp_q.pop_front();
                if (out_reg !== e.r || out_data !== e.d || out_last !== e.l) begin
                    errors++;
                    $display("FAIL beat: got reg=%0d data=%0d last=%0d, want reg=%0d data=%0d last=%0d",
                             out_reg, out_data, out_last, e.r, e.d, e.l);
                end else begin
                    $display("beat reg=%0d data=%0d last=%0d ok", out_reg, out_data, out_last);
                end
            end
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic push(input int r, input logic [31:0] d, input logic l);
        beat_t b;
        b.r = 5'(r);
        b.d = d;
        b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input int f, input int l);
        start     = 1'b1;
        first_reg = 5'(f);
        last_reg  = 5'(l);
        tick();
        start     = 1'b0;
        first_reg = 5'd0;
        last_reg  = 5'd0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles", name, budget);
        end
    endtask

    task automatic fill_regs();
        for (int k = 0; k < 32; k++) regs[k] = 32'(k + 100);
    endtask

    initial begin
        int d0;
        int n;
        fill_regs();
        reset     = 1'b1;
        start     = 1'b0;
        first_reg = 5'd0;
        last_reg  = 5'd0;
        out_ready = 1'b1;

        // Reset state, with start asserted to show reset wins.
        tick();
        start = 1'b1;
        first_reg = 5'd3;
        last_reg  = 5'd4;
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(ctrl_readReg), 0);
        chk("rst_data", out_data, 0);
        chk("rst_reg", 32'(out_reg), 0);
        chk("rst_last", 32'(out_last), 0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 0);

        // Single beat, latency and done timing.
        regs[1] = 32'd9999;
        regs[9] = 32'd9998;
        push(1, 32'd9999, 1'b1);
        d0 = done_cnt;
        do_start(1, 1);                  // now in cycle N+1
        chk("lat_n1_valid", 32'(out_valid), 0);
        chk("lat_n1_addr", 32'(ctrl_readReg), 1);
        chk("lat_n1_busy", 32'(busy), 1);
        tick();                          // N+2
        chk("lat_n2_valid", 32'(out_valid), 1);
        chk("lat_n2_addr", 32'(ctrl_readReg), 0);
        tick();                          // N+3
        chk("lat_n3_done", 32'(done), 1);
        chk("lat_n3_valid", 32'(out_valid), 0);
        tick();
        chk("lat_n4_done", 32'(done), 0);
        chk("lat_n4_busy", 32'(busy), 0);
        chk("single_done_cnt", 32'(done_cnt - d0), 1);

        // Full range 0..31.
        fill_regs();
        for (int k = 0; k < 32; k++) push(k, 32'(k + 100), k == 31);
        d0 = done_cnt;
        do_start(0, 31);
        wait_idle("full", 200);
        tick();
        chk("full_done_cnt", 32'(done_cnt - d0), 1);
        chk("full_queue_left", 32'(exp_q.size()), 0);

        // Wrapping range 30..1.
        push(30, 32'd130, 1'b0);
        push(31, 32'd131, 1'b0);
        push(0, 32'd100, 1'b0);
        push(1, 32'd101, 1'b1);
        d0 = done_cnt;
        do_start(30, 1);
        wait_idle("wrap", 50);
        tick();
        chk("wrap_done_cnt", 32'(done_cnt - d0), 1);
        chk("wrap_queue_left", 32'(exp_q.size()), 0);

        // Backpressure: hold out_ready low for 5 cycles of a SEND.
        regs[6] = 32'd9999;
        out_ready = 1'b0;
        push(6, 32'd9999, 1'b1);
        do_start(6, 6);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", out_data, 32'd9999);
            chk("stall_reg", 32'(out_reg), 6);
            if (c < 4) tick();
        end
        out_ready = 1'b1;
        tick();
        chk("stall_xfer_done", 32'(done), 1);
        wait_idle("stall", 10);
        chk("stall_queue_left", 32'(exp_q.size()), 0);

        // Reset during the r4 beat of a 0..7 dump.
        fill_regs();
        for (int k = 0; k < 4; k++) push(k, 32'(k + 100), 1'b0);
        d0 = done_cnt;
        do_start(0, 7);
        n = 0;
        while (!(out_valid && out_reg == 5'd4) && n < 40) begin
            tick();
            n++;
        end
        chk("abort_at_r4", 32'(out_reg), 4);
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_data", out_data, 0);
        chk("abort_reg", 32'(out_reg), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        chk("abort_queue_left", 32'(exp_q.size()), 0);
        push(2, 32'd102, 1'b1);
        do_start(2, 2);
        wait_idle("after_abort", 20);
        chk("after_abort_queue", 32'(exp_q.size()), 0);

        // Start while busy must be ignored.
        push(10, 32'd110, 1'b0);
        push(11, 32'd111, 1'b0);
        push(12, 32'd112, 1'b1);
        d0 = done_cnt;
        do_start(10, 12);
        start     = 1'b1;
        first_reg = 5'd20;
        last_reg  = 5'd25;
        tick();
        tick();
        tick();
        start     = 1'b0;
        first_reg = 5'd0;
        last_reg  = 5'd0;
        wait_idle("busy_start", 30);
        tick();
        chk("busy_start_idle", 32'(busy), 0);
        chk("busy_start_done_cnt", 32'(done_cnt - d0), 1);
        chk("busy_start_queue", 32'(exp_q.size()), 0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
